sc_stream_encoder: RTL and testbench
====================================

# sc_stream_encoder

Serial stochastic-number generator (SNG) for the SC datapath. It accepts one binary magnitude per handshake and emits a unipolar stochastic bitstream of STREAM_LENGTH bits, one bit per accepted beat. The stream contains exactly that many ones, placed by a bit-reversed counter (Sobol dimension-1 / van der Corput) sequence. It is the binary-to-stream producer that feeds serial SC operators; the parallel APC converts streams back to binary.

## Interface
- DATA_WIDTH, 6: width of the input magnitude; must satisfy 2^(DATA_WIDTH-1) ≥ STREAM_LENGTH.
- STREAM_LENGTH, 32: bits per stream; power of two.
- LOG_LEN, 5: log2(STREAM_LENGTH); width of the beat counter.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  encoder can accept a value this cycle.
- in_value  input  DATA_WIDTH  unsigned count of ones requested, 0..STREAM_LENGTH.
- out_valid  output  1  out_bit is valid.
- out_ready  input  1  downstream accepts the current bit.
- out_bit  output  1  current stochastic bit.
- out_last  output  1  current bit is beat STREAM_LENGTH-1 of the stream.
- ones_count  output  LOG_LEN+1  popcount of the last completed stream (SC_ENC_ACCUM_EN only).
- count_valid  output  1  one-cycle pulse: ones_count has been updated (SC_ENC_ACCUM_EN only).

## Operation
- States: IDLE, STREAM. Registers: val_q (LOG_LEN+1 bits), cnt_q (LOG_LEN bits), state.
- Input saturation: if in_value > STREAM_LENGTH, latch STREAM_LENGTH.
- IDLE: in_ready=1, out_valid=0. On in_valid: latch val_q, set cnt_q=0, go to STREAM.
- STREAM: out_valid=1. out_bit = (val_q > bitrev(cnt_q)), where bitrev reverses the LOG_LEN counter bits, zero-extended. out_last = (cnt_q == STREAM_LENGTH-1).
- Beat handshake is out_valid & out_ready. On a non-last beat, cnt_q increments.
- Last beat: if in_valid is also high, latch the new value, set cnt_q=0 and stay in STREAM (back-to-back, no bubble). Otherwise return to IDLE.
- in_ready is 1 in IDLE. In STREAM, in_ready = out_last & out_ready. It is combinational, but it never depends on in_valid.
- Stall (out_ready=0): out_bit, out_last, cnt_q and val_q hold; the stream is not corrupted.
- Guarantee: every stream of value v contains exactly v ones. v=0 gives all zeros; v=STREAM_LENGTH gives all ones.
- in_value is sampled only on an input handshake. A change of in_value mid-stream has no effect.

## Timing
- Reset (async assert, sync release): state=IDLE, cnt_q=0, val_q=0, out_valid=0, out_bit=0, out_last=0, in_ready=1, ones_count=0, count_valid=0.
- Latency: input handshake at edge N gives the first bit valid in cycle N+1, i.e. after that edge.
- Throughput: one bit per cycle when out_ready=1. A stream takes exactly STREAM_LENGTH cycles, with zero gap between back-to-back streams.
- Reset asserted mid-stream: the stream is aborted immediately and no partial count is reported.
- cnt_q wraps to 0 only through the last-beat rule; it never wraps freely.

## Configuration
- SC_ENC_ACCUM_EN defined:
  - An internal (LOG_LEN+1)-bit accumulator adds out_bit on every beat and clears at the start of each stream.
  - On the last beat, the final sum (including that bit) is registered into ones_count, and count_valid pulses for one cycle in the following cycle.
  - This acts as an on-chip self-check that ones_count equals the latched value.
- SC_ENC_ACCUM_EN undefined:
  - No accumulator logic is built.
  - ones_count is tied to 0 and count_valid to 0.
  - The ports remain present.

## Test plan
- Reset, then in_value=0, out_ready=1 held -> 32 bits all 0; out_last only on beat 31; state returns to IDLE, in_ready=1.
- in_value=32 -> 32 ones. in_value=45 (saturation) -> 32 ones, ones_count=32.
- in_value=16 -> beats 0..7 read 1,0,1,0,1,0,1,0 (bitrev 0,16,8,24,4,20,12,28); total 16 ones; ones_count=16 with count_valid one cycle after the last beat.
- Back-to-back: in_valid held with 5 then 27 -> 64 consecutive valid beats, no gap; stream popcounts 5 and 27.
- Random out_ready stalls (about 50%) with in_value=13 -> the bit sequence matches the unstalled reference sequence; exactly 13 ones; out_bit is stable while stalled.
- Assert rst_n=0 at beat 10 of in_value=20 -> out_valid=0 immediately; count_valid never pulses; the next stream of value 3 gives exactly 3 ones.

Source files
------------

// File: rtl/sc_stream_encoder.sv
// sc_stream_encoder: serial stochastic-number generator.
// Accepts one binary magnitude per input handshake and emits a unipolar
// bitstream of STREAM_LENGTH bits. Each bit compares the latched value against
// the bit-reversed beat counter (van der Corput order). The result is that a
// stream of value v contains exactly v ones, spread evenly along the stream.
//
// Optional build macro: SC_ENC_ACCUM_EN
//   defined   -> a popcount accumulator reports each completed stream on
//                ones_count and pulses count_valid for one cycle.
//   undefined -> no accumulator is built; ones_count and count_valid read 0.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no stream in flight; in_ready=1, waiting for an input value
// STREAM | presenting bit cnt_q of the stream for val_q; out_valid=1
module sc_stream_encoder #(
    parameter int DATA_WIDTH    = 6,
    parameter int STREAM_LENGTH = 32,
    parameter int LOG_LEN       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_value,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_bit,
    output logic                  out_last,
    output logic [LOG_LEN:0]      ones_count,
    output logic                  count_valid
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic [DATA_WIDTH-1:0] LEN_IN   = DATA_WIDTH'(STREAM_LENGTH);
    localparam logic [LOG_LEN-1:0]    CNT_LAST = LOG_LEN'(STREAM_LENGTH - 1);

    state_t               state_q, state_d;
    logic [LOG_LEN:0]     val_q, val_d;
    logic [LOG_LEN-1:0]   cnt_q, cnt_d;
    logic [LOG_LEN-1:0]   cnt_rev;
    logic [DATA_WIDTH-1:0] in_sat;
    logic [LOG_LEN:0]     in_val_sat;
    logic                 beat;

    // Values above the stream length would ask for more ones than beats exist.
    always_comb begin
        in_sat = (in_value > LEN_IN) ? LEN_IN : in_value;
    end

    // After saturation the value always fits in LOG_LEN+1 bits.
    assign in_val_sat = (LOG_LEN + 1)'(in_sat);

    // Bit-reversed beat counter: the low-discrepancy threshold sequence.
    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < LOG_LEN; i++) begin
            cnt_rev[i] = cnt_q[LOG_LEN-1-i];
        end
    end

    // Stream outputs and the input-side ready, all gated by the FSM state.
    always_comb begin
        out_valid = (state_q == STREAM);
        out_last  = out_valid && (cnt_q == CNT_LAST);
        out_bit   = out_valid && (val_q > {1'b0, cnt_rev});
        // Ready in STREAM only on the accepted last beat, so a new value can
        // follow back-to-back; it deliberately ignores in_valid.
        in_ready  = out_valid ? (out_last & out_ready) : 1'b1;
        beat      = out_valid & out_ready;
    end

    // Next-state logic: latch on input handshake, advance on each beat.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d   = in_val_sat;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (beat) begin
                    if (!out_last) begin
                        cnt_d = cnt_q + LOG_LEN'(1);
                    end else if (in_valid) begin
                        val_d = in_val_sat;
                        cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, value and beat-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SC_ENC_ACCUM_EN
    logic [LOG_LEN:0] acc_q;
    logic [LOG_LEN:0] ones_q;
    logic             cv_q;
    logic [LOG_LEN:0] acc_sum;

    // Running popcount including the bit on the current beat.
    assign acc_sum = acc_q + (LOG_LEN + 1)'(out_bit);

    // Accumulate per beat; publish and clear on the last beat. Reset discards
    // any partial stream, so an aborted stream never reports a count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            ones_q <= '0;
            cv_q   <= 1'b0;
        end else begin
            cv_q <= 1'b0;
            if (beat) begin
                if (out_last) begin
                    ones_q <= acc_sum;
                    cv_q   <= 1'b1;
                    acc_q  <= '0;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign ones_count  = ones_q;
    assign count_valid = cv_q;
`else
    assign ones_count  = '0;
    assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sc_stream_encoder.sv
// Self-checking bench for sc_stream_encoder: a queue-based stream model is
// compared against the DUT every cycle, plus directed literal checks.
module tb_sc_stream_encoder;

    localparam int DW = 6;
    localparam int SL = 32;
    localparam int LL = 5;

`ifdef SC_ENC_ACCUM_EN
    localparam int ACC = 1;
`else
    localparam int ACC = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_value = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_bit;
    logic          out_last;
    logic [LL:0]   ones_count;
    logic          count_valid;

    sc_stream_encoder #(.DATA_WIDTH(DW), .STREAM_LENGTH(SL), .LOG_LEN(LL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_last   (out_last),
        .ones_count (ones_count),
        .count_valid(count_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int i = 0; i < LL; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    function automatic int sat(input int v);
        return (v > SL) ? SL : v;
    endfunction

    function automatic logic [31:0] ref_stream(input int v);
        logic [31:0] r = '0;
        for (int k = 0; k < SL; k++) r[k] = (sat(v) > bitrev(k));
        return r;
    endfunction

    // ---------------- behavioural model: queue of pending beats ----------
    typedef struct {
        bit b;
        bit last;
        int cnt;
    } beat_t;

    beat_t mq[$];
    bit    m_cv = 0;
    int    m_oc = 0;

    always begin : model
        bit e_valid, e_bit, e_last, e_rdy, acc_hs, do_beat;
        @(negedge clk);
        acc_hs  = 0;
        do_beat = 0;
        if (rst_n) begin
            e_valid = (mq.size() > 0);
            e_bit   = e_valid ? mq[0].b : 1'b0;
            e_last  = e_valid ? mq[0].last : 1'b0;
            e_rdy   = !e_valid || (e_last && out_ready);
            chk("out_valid", int'(out_valid), int'(e_valid));
            chk("out_bit", int'(out_bit), int'(e_bit));
            chk("out_last", int'(out_last), int'(e_last));
            chk("in_ready", int'(in_ready), int'(e_rdy));
            chk("count_valid", int'(count_valid), ACC != 0 ? int'(m_cv) : 0);
            chk("ones_count", int'(ones_count), ACC != 0 ? m_oc : 0);
            acc_hs  = in_valid && e_rdy;
            do_beat = e_valid && out_ready;
        end
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_cv = 0;
            m_oc = 0;
        end else begin
            m_cv = 0;
            if (do_beat) begin
                if (mq[0].last) begin
                    m_cv = 1;
                    m_oc = mq[0].cnt;
                end
                void'(mq.pop_front());
            end
            if (acc_hs) begin
                for (int k = 0; k < SL; k++) begin
                    beat_t e;
                    e.b    = (sat(int'(in_value)) > bitrev(k));
                    e.last = (k == SL - 1);
                    e.cnt  = sat(int'(in_value));
                    mq.push_back(e);
                end
            end
        end
    end

    // ---------------- capture of DUT streams for directed checks ---------
    int          cur_beats = 0;
    int          cur_ones  = 0;
    logic [31:0] cur_bits  = '0;
    logic [31:0] last_bits = '0;
    int          last_len  = 0;
    int          pops_q[$];
    bit          cv_seen   = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_beats = 0;
            cur_ones  = 0;
            cur_bits  = '0;
        end else begin
            if (count_valid) cv_seen = 1;
            if (out_valid && out_ready) begin
                if (cur_beats < 32) cur_bits[cur_beats] = out_bit;
                if (out_bit) cur_ones++;
                cur_beats++;
                if (out_last) begin
                    last_bits = cur_bits;
                    last_len  = cur_beats;
                    pops_q.push_back(cur_ones);
                    cur_beats = 0;
                    cur_ones  = 0;
                    cur_bits  = '0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic send(input int v);
        bit ok = 0;
        in_value = v[DW-1:0];
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic wait_last(input int budget, input bit rnd_ready);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (out_valid && out_ready && out_last) ok = 1;
            @(posedge clk);
            #1;
        end
        chk("stream_end", int'(ok), 1);
    endtask

    task automatic check_pops1(input string name, input int exp);
        chk({name, "_n"}, pops_q.size(), 1);
        if (pops_q.size() > 0) chk(name, pops_q[0], exp);
        pops_q.delete();
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin
        int gaps;
        bit got_first, got_second;

        // reset values
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_ones_count", int'(ones_count), 0);
        chk("rst_count_valid", int'(count_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // value 0: all zeros, 32 beats, back to idle
        out_ready = 1'b1;
        pops_q.delete();
        send(0);
        wait_last(100, 0);
        check_pops1("pop_v0", 0);
        chk("len_v0", last_len, 32);
        chk("bits_v0", int'(last_bits), 0);
        @(negedge clk);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;

        // full scale and saturation
        send(32);
        wait_last(100, 0);
        check_pops1("pop_v32", 32);
        send(45);
        wait_last(100, 0);
        check_pops1("pop_v45", 32);
        chk("cv_v45", int'(count_valid), ACC);
        chk("oc_v45", int'(ones_count), ACC != 0 ? 32 : 0);
        @(posedge clk);
        #1;
        chk("cv_v45_one_cycle", int'(count_valid), 0);

        // half scale: alternating pattern from the bit-reversed order
        send(16);
        wait_last(100, 0);
        chk("first8_v16", int'(last_bits[7:0]), 8'h55);
        check_pops1("pop_v16", 16);
        chk("oc_v16", int'(ones_count), ACC != 0 ? 16 : 0);

        // back-to-back 5 then 27, no bubble
        pops_q.delete();
        in_value   = 6'd5;
        in_valid   = 1'b1;
        got_first  = 0;
        for (int i = 0; i < 50 && !got_first; i++) begin
            @(negedge clk);
            if (in_ready) got_first = 1;
            @(posedge clk);
            #1;
        end
        chk("b2b_first_accept", int'(got_first), 1);
        in_value   = 6'd27;
        gaps       = 0;
        got_second = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
            if (in_ready && in_valid) got_second = 1;
            @(posedge clk);
            #1;
            if (got_second) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("b2b_gaps", gaps, 0);
        chk("b2b_second_accept", int'(got_second), 1);
        chk("b2b_n", pops_q.size(), 2);
        if (pops_q.size() == 2) begin
            chk("b2b_pop_5", pops_q[0], 5);
            chk("b2b_pop_27", pops_q[1], 27);
        end
        pops_q.delete();

        // random stalls with value 13
        send(13);
        wait_last(400, 1);
        out_ready = 1'b1;
        chk("stall_seq_v13", int'(last_bits), int'(ref_stream(13)));
        check_pops1("pop_v13", 13);

        // reset at beat 10 of value 20
        @(posedge clk);
        #1;
        pops_q.delete();
        cv_seen = 0;
        send(20);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_bit", int'(out_bit), 0);
        chk("abort_count_valid", int'(count_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_cv", int'(cv_seen), 0);
        chk("abort_no_pop", pops_q.size(), 0);
        send(3);
        wait_last(100, 0);
        check_pops1("pop_v3", 3);
        chk("oc_v3", int'(ones_count), ACC != 0 ? 3 : 0);

        // randomized traffic, checked by the model
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_value  = DW'($urandom_range(0, 63));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_idle", int'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
